stage_execute_md: RTL
=====================

// Module: stage_execute_md
// PURPOSE
// Parametrised EX pipeline stage: operand forwarding, ALU source select, single-cycle ALU and
// optional multi-cycle RV32M multiply/divide unit. Registers EX/MEM output (result, store data, rd,
// control). Sits between decode (ID/EX regs) and memory stage; stalls upstream during mul/div.
// PARAMETERS
// XLEN        32  datapath width; shift amount uses low $clog2(XLEN) bits
// MULDIV_EN   1   1: implement M ops; 0: M ops yield 0, never stall
// MUL_STAGES  2   multiply latency in cycles (>=1); divide latency fixed at XLEN cycles
// PORTS
// i_Clock          in   1     clock
// i_Reset          in   1     synchronous, active-high reset
// i_Valid          in   1     instruction present in EX
// i_Flush          in   1     kill instruction in EX (incl. in-flight mul/div)
// i_MemStall       in   1     downstream hold: output regs and FSM freeze
// o_Stall          out  1     hold ID/EX (mul/div busy); combinational
// i_AluOp          in   5     0 ADD,1 SUB,2 SLL,3 SLT,4 SLTU,5 XOR,6 SRL,7 SRA,8 OR,9 AND,
//                             10 MUL,11 MULH,12 MULHSU,13 MULHU,14 DIV,15 DIVU,16 REM,17 REMU
// i_AluSrc1        in   2     0 rs1, 1 PC, 2/3 zero
// i_AluSrc2        in   2     0 rs2, 1 imm, 2 const 4, 3 zero
// i_PC,i_Imm       in   XLEN  PC / sign-extended immediate
// i_Rs1Value,i_Rs2Value in XLEN register-file read data
// i_Rs1,i_Rs2,i_Rd in   5     register indices
// i_RegWrite,i_MemRead,i_MemWrite in 1 control passed through to output
// i_ExMemRd,i_ExMemRegWrite,i_ExMemValue in 5/1/XLEN  forward source 1 (higher priority)
// i_MemWbRd,i_MemWbRegWrite,i_MemWbValue in 5/1/XLEN  forward source 2
// o_Valid          out  1     EX/MEM register valid
// o_Result,o_StoreData out XLEN ALU result / forwarded rs2 value
// o_Rd,o_RegWrite,o_MemRead,o_MemWrite out 5/1/1/1 registered rd and control
// BEHAVIOUR
// - Reset: all outputs 0, FSM IDLE, o_Stall 0.
// - Forwarding per rs: EX/MEM if RegWrite && Rd==rs && rs!=0; else MEM/WB likewise; else regfile.
//   x0 never forwarded. Forwarded rs2 drives both AluSrc2=0 and o_StoreData.
// - Single-cycle ops: result registered at next edge; o_Valid follows i_Valid. Add/sub wrap mod 2^XLEN.
// - Output reg update priority: i_MemStall (hold all) > i_Flush or busy (load bubble: o_Valid and
//   control bits 0, data don't-care) > load new instruction.
// - FSM IDLE/MUL/DIV/DONE. IDLE + valid M op (no flush, no MemStall): capture forwarded operands,
//   go MUL or DIV; o_Stall=1 this cycle. Captured operands used thereafter (forward sources change).
// - Op started in cycle T completes with result registered at edge ending cycle T+N (N=MUL_STAGES or
//   XLEN); o_Stall=1 for cycles T..T+N-1, 0 in T+N; output bubbles during T..T+N-1.
// - DONE reached and i_MemStall high: stay DONE, o_Stall=1 until written.
// - Div by zero: quotient all-ones, remainder = dividend. Signed overflow (MIN/-1): quotient MIN,
//   remainder 0. Both take the full N cycles. MULH* return upper XLEN bits of 2*XLEN product.
// - i_Flush in any state: FSM->IDLE next cycle, o_Stall 0 next cycle, result discarded.
// - MULDIV_EN=0: ops 10-17 and 18-31 give result 0, single-cycle, no stall.
// TESTING
// - ADD x3=x1+x2, x1=5 fwd from EX/MEM, MEM/WB also rd=1 val 9 -> o_Result 5+x2 (EX/MEM wins).
// - rs1=0, EX/MEM Rd=0 RegWrite=1 val 7 -> operand 0; SRA 0x80000000 by 33 -> 0xC0000000.
// - MUL 0xFFFFFFFF*2 (MUL_STAGES=2) -> o_Stall 2 cycles, o_Result 0xFFFFFFFE; MULHU -> 0x00000001.
// - DIV 0x80000000/-1 -> 0x80000000, REM -> 0; DIVU 7/0 -> 0xFFFFFFFF, REMU 7/0 -> 7; 32 stall cycles.
// - i_Flush at cycle 5 of DIV -> o_Stall 0 next cycle, no valid output, next ADD proceeds normally.
// - i_MemStall held 3 cycles as DIV completes -> result, o_Valid, o_Stall held, written after release.

Source files
------------

// File: rtl/stage_execute_md_if.sv
// Signal bundle between the ID/EX registers, the forwarding network and the EX/MEM register of the execute stage.
interface stage_execute_md_if #(
    parameter int XLEN = 32
);
    logic            i_Valid;
    logic            i_Flush;
    logic            i_MemStall;
    logic            o_Stall;
    logic [4:0]      i_AluOp;
    logic [1:0]      i_AluSrc1;
    logic [1:0]      i_AluSrc2;
    logic [XLEN-1:0] i_PC;
    logic [XLEN-1:0] i_Imm;
    logic [XLEN-1:0] i_Rs1Value;
    logic [XLEN-1:0] i_Rs2Value;
    logic [4:0]      i_Rs1;
    logic [4:0]      i_Rs2;
    logic [4:0]      i_Rd;
    logic            i_RegWrite;
    logic            i_MemRead;
    logic            i_MemWrite;
    logic [4:0]      i_ExMemRd;
    logic            i_ExMemRegWrite;
    logic [XLEN-1:0] i_ExMemValue;
    logic [4:0]      i_MemWbRd;
    logic            i_MemWbRegWrite;
    logic [XLEN-1:0] i_MemWbValue;
    logic            o_Valid;
    logic [XLEN-1:0] o_Result;
    logic [XLEN-1:0] o_StoreData;
    logic [4:0]      o_Rd;
    logic            o_RegWrite;
    logic            o_MemRead;
    logic            o_MemWrite;

    modport slave (
        input  i_Valid, i_Flush, i_MemStall, i_AluOp, i_AluSrc1, i_AluSrc2, i_PC, i_Imm,
               i_Rs1Value, i_Rs2Value, i_Rs1, i_Rs2, i_Rd, i_RegWrite, i_MemRead, i_MemWrite,
               i_ExMemRd, i_ExMemRegWrite, i_ExMemValue, i_MemWbRd, i_MemWbRegWrite, i_MemWbValue,
        output o_Stall, o_Valid, o_Result, o_StoreData, o_Rd, o_RegWrite, o_MemRead, o_MemWrite
    );

    modport master (
        output i_Valid, i_Flush, i_MemStall, i_AluOp, i_AluSrc1, i_AluSrc2, i_PC, i_Imm,
               i_Rs1Value, i_Rs2Value, i_Rs1, i_Rs2, i_Rd, i_RegWrite, i_MemRead, i_MemWrite,
               i_ExMemRd, i_ExMemRegWrite, i_ExMemValue, i_MemWbRd, i_MemWbRegWrite, i_MemWbValue,
        input  o_Stall, o_Valid, o_Result, o_StoreData, o_Rd, o_RegWrite, o_MemRead, o_MemWrite
    );
endinterface

// File: rtl/stage_execute_md.sv
// Execute stage: forwarding, ALU, iterative RV32M multiply/divide and the EX/MEM output register.
//   state | meaning
//   IDLE  | no M op in flight; single-cycle ops flow through
//   MUL   | multiply latency count on captured operands
//   DIV   | restoring divide, one quotient bit per cycle
//   DONE  | M result ready; written to EX/MEM when not held downstream
module stage_execute_md #(
    parameter int XLEN       = 32,
    parameter int MULDIV_EN  = 1,
    parameter int MUL_STAGES = 2
) (
    input  logic              i_Clock,
    input  logic              i_Reset,
    stage_execute_md_if.slave ex
);
    localparam int SHW  = $clog2(XLEN);
    localparam int NMAX = (MUL_STAGES > XLEN) ? MUL_STAGES : XLEN;
    localparam int CW   = $clog2(NMAX + 1);

    localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB = 5'd1,  OP_SLL = 5'd2,  OP_SLT = 5'd3;
    localparam logic [4:0] OP_SLTU = 5'd4, OP_XOR = 5'd5,  OP_SRL = 5'd6,  OP_SRA = 5'd7;
    localparam logic [4:0] OP_OR = 5'd8,   OP_AND = 5'd9,  OP_MUL = 5'd10, OP_MULH = 5'd11;
    localparam logic [4:0] OP_MULHSU = 5'd12, OP_MULHU = 5'd13, OP_DIV = 5'd14, OP_DIVU = 5'd15;
    localparam logic [4:0] OP_REM = 5'd16, OP_REMU = 5'd17;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [4:0]      mop_q;
    logic [XLEN-1:0] a_q, b_q, rem_q, quo_q;

    logic [XLEN-1:0] rs1_val, rs2_val, op_a, op_b, alu_res, md_res;
    logic [SHW-1:0]  shamt;
    logic            is_mop, is_div, start, stall, div_step, md_wr;
    logic            start_signed, cap_signed;

    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic sgn);
        return (sgn && v[XLEN-1]) ? -v : v;
    endfunction

    // x0 is never forwarded; the EX/MEM source wins over MEM/WB
    always_comb begin
        rs1_val = ex.i_Rs1Value;
        if (ex.i_Rs1 != 5'd0 && ex.i_ExMemRegWrite && ex.i_ExMemRd == ex.i_Rs1)
            rs1_val = ex.i_ExMemValue;
        else if (ex.i_Rs1 != 5'd0 && ex.i_MemWbRegWrite && ex.i_MemWbRd == ex.i_Rs1)
            rs1_val = ex.i_MemWbValue;
        rs2_val = ex.i_Rs2Value;
        if (ex.i_Rs2 != 5'd0 && ex.i_ExMemRegWrite && ex.i_ExMemRd == ex.i_Rs2)
            rs2_val = ex.i_ExMemValue;
        else if (ex.i_Rs2 != 5'd0 && ex.i_MemWbRegWrite && ex.i_MemWbRd == ex.i_Rs2)
            rs2_val = ex.i_MemWbValue;
    end

    always_comb begin
        case (ex.i_AluSrc1)
            2'd0:    op_a = rs1_val;
            2'd1:    op_a = ex.i_PC;
            default: op_a = '0;
        endcase
        case (ex.i_AluSrc2)
            2'd0:    op_b = rs2_val;
            2'd1:    op_b = ex.i_Imm;
            2'd2:    op_b = XLEN'(4);
            default: op_b = '0;
        endcase
    end

    assign shamt = op_b[SHW-1:0];

    always_comb begin
        case (ex.i_AluOp)
            OP_ADD:  alu_res = op_a + op_b;
            OP_SUB:  alu_res = op_a - op_b;
            OP_SLL:  alu_res = op_a << shamt;
            OP_SLT:  alu_res = XLEN'($signed(op_a) < $signed(op_b));
            OP_SLTU: alu_res = XLEN'(op_a < op_b);
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_SRL:  alu_res = op_a >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(op_a) >>> shamt);
            OP_OR:   alu_res = op_a | op_b;
            OP_AND:  alu_res = op_a & op_b;
            default: alu_res = '0;
        endcase
    end

    assign is_mop       = (MULDIV_EN != 0) && (ex.i_AluOp >= OP_MUL) && (ex.i_AluOp <= OP_REMU);
    assign is_div       = ex.i_AluOp >= OP_DIV;
    assign start        = (state_q == S_IDLE) && ex.i_Valid && is_mop && !ex.i_Flush && !ex.i_MemStall;
    assign start_signed = (ex.i_AluOp == OP_DIV) || (ex.i_AluOp == OP_REM);
    assign cap_signed   = (mop_q == OP_DIV) || (mop_q == OP_REM);

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (ex.i_Flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (start) begin
                    cnt_d = is_div ? CW'(XLEN - 1) : CW'(MUL_STAGES - 1);
                    if (is_div)               state_d = S_DIV;
                    else if (MUL_STAGES == 1) state_d = S_DONE;
                    else                      state_d = S_MUL;
                end
                S_MUL, S_DIV: if (!ex.i_MemStall) begin
                    if (cnt_q == CW'(1)) state_d = S_DONE;
                    else                 cnt_d   = cnt_q - CW'(1);
                end
                S_DONE: if (!ex.i_MemStall) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        stall    = 1'b0;
        div_step = 1'b0;
        md_wr    = 1'b0;
        case (state_q)
            S_IDLE: begin
                stall    = ex.i_Valid && is_mop && !ex.i_Flush;
                div_step = start && is_div;
            end
            S_MUL:  stall = 1'b1;
            S_DIV: begin
                stall    = 1'b1;
                div_step = !ex.i_MemStall && !ex.i_Flush;
            end
            S_DONE: begin
                stall = ex.i_MemStall;
                md_wr = !ex.i_MemStall && !ex.i_Flush;
            end
            default: stall = 1'b0;
        endcase
    end

    // One restoring-division step; the first one happens on the capture edge itself
    logic [XLEN-1:0] st_rem_in, st_quo_in, st_den, st_rem, st_quo;
    logic [XLEN:0]   rem_sh;
    logic            st_ge;

    always_comb begin
        if (start) begin
            st_rem_in = '0;
            st_quo_in = mag(op_a, start_signed);
            st_den    = mag(op_b, start_signed);
        end else begin
            st_rem_in = rem_q;
            st_quo_in = quo_q;
            st_den    = mag(b_q, cap_signed);
        end
        rem_sh = {st_rem_in, st_quo_in[XLEN-1]};
        st_ge  = rem_sh >= {1'b0, st_den};
        st_rem = st_ge ? (rem_sh[XLEN-1:0] - st_den) : rem_sh[XLEN-1:0];
        st_quo = {st_quo_in[XLEN-2:0], st_ge};
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            mop_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            rem_q <= '0;
            quo_q <= '0;
        end else begin
            if (start) begin
                mop_q <= ex.i_AluOp;
                a_q   <= op_a;
                b_q   <= op_b;
            end
            if (div_step) begin
                rem_q <= st_rem;
                quo_q <= st_quo;
            end
        end
    end

    logic [2*XLEN-1:0] ext_a, ext_b, prod;
    logic [XLEN-1:0]   q_fix, r_fix;

    // Divide by zero and MIN/-1 fall out of the unsigned core except for the zero-divisor signs
    always_comb begin
        ext_a = {{XLEN{((mop_q == OP_MULH) || (mop_q == OP_MULHSU)) & a_q[XLEN-1]}}, a_q};
        ext_b = {{XLEN{(mop_q == OP_MULH) & b_q[XLEN-1]}}, b_q};
        prod  = ext_a * ext_b;
        q_fix = (cap_signed && (a_q[XLEN-1] ^ b_q[XLEN-1])) ? -quo_q : quo_q;
        r_fix = (cap_signed && a_q[XLEN-1]) ? -rem_q : rem_q;
        if (b_q == '0) begin
            q_fix = '1;
            r_fix = a_q;
        end
        case (mop_q)
            OP_MUL:                        md_res = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  md_res = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               md_res = q_fix;
            OP_REM, OP_REMU:               md_res = r_fix;
            default:                       md_res = '0;
        endcase
    end

    logic            valid_q, regwrite_q, memread_q, memwrite_q;
    logic [XLEN-1:0] result_q, store_q;
    logic [4:0]      rd_q;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            valid_q    <= 1'b0;
            result_q   <= '0;
            store_q    <= '0;
            rd_q       <= '0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
        end else if (!ex.i_MemStall) begin
            if (ex.i_Flush || stall) begin
                valid_q    <= 1'b0;
                regwrite_q <= 1'b0;
                memread_q  <= 1'b0;
                memwrite_q <= 1'b0;
            end else begin
                valid_q    <= ex.i_Valid;
                result_q   <= md_wr ? md_res : alu_res;
                store_q    <= rs2_val;
                rd_q       <= ex.i_Rd;
                regwrite_q <= ex.i_Valid & ex.i_RegWrite;
                memread_q  <= ex.i_Valid & ex.i_MemRead;
                memwrite_q <= ex.i_Valid & ex.i_MemWrite;
            end
        end
    end

    assign ex.o_Stall     = stall;
    assign ex.o_Valid     = valid_q;
    assign ex.o_Result    = result_q;
    assign ex.o_StoreData = store_q;
    assign ex.o_Rd        = rd_q;
    assign ex.o_RegWrite  = regwrite_q;
    assign ex.o_MemRead   = memread_q;
    assign ex.o_MemWrite  = memwrite_q;
endmodule
